// File: rtl/bcd_counter_7seg_mux.sv
`default_nettype none
// ============================================================================
// bcd_counter_7seg_mux : multi-digit BCD up/down counter with load, wrap pulse
//                        and a registered, time-multiplexed 7-segment driver.
// Revision 1.0
// ============================================================================
module bcd_counter_7seg_mux #(
  parameter int DIGITS     = 3,
  parameter int SCAN_DIV   = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  count_en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
  localparam logic [7:0]        SEG_RST  = (ACTIVE_LOW != 0) ? ~8'h3F : 8'h3F;
  localparam logic [DIGITS-1:0] AN_RST   = (ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [DIV_W-1:0]    div_q;
  logic [IDX_W-1:0]    scan_idx;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                carry;
  logic                nonzero_above;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          sel_digit;
  logic                sel_blank;
  logic [7:0]          seg_raw;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'h3F;
      4'd1:    seg_pat = 7'h06;
      4'd2:    seg_pat = 7'h5B;
      4'd3:    seg_pat = 7'h4F;
      4'd4:    seg_pat = 7'h66;
      4'd5:    seg_pat = 7'h6D;
      4'd6:    seg_pat = 7'h7D;
      4'd7:    seg_pat = 7'h07;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h6F;
      default: seg_pat = 7'h00;
    endcase
  endfunction

  // Carry/borrow ripples through all digits in one cycle; a carry out of the top is a wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    if (load) begin
      for (int k = 0; k < DIGITS; k++)
        count_d[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
    end else if (count_en) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (up) begin
            if (count_q[4*k +: 4] == 4'd9) count_d[4*k +: 4] = 4'd0;
            else begin
              count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (count_q[4*k +: 4] == 4'd0) count_d[4*k +: 4] = 4'd9;
            else begin
              count_d[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      div_q   <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  generate
    if (DIGITS > 1) begin : g_scan_multi
      localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
      logic [IDX_W-1:0] idx_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_q <= '0;
        else if (div_q == DIV_LAST) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      assign scan_idx = idx_q;
    end else begin : g_scan_single
      assign scan_idx = '0;
    end
  endgenerate

  // A digit above digit 0 blanks only when it and every higher digit are zero.
  always_comb begin
    blank         = '0;
    nonzero_above = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      nonzero_above = nonzero_above | (count_q[4*k +: 4] != 4'd0);
      blank[k]      = (BLANK_LZ != 0) && !nonzero_above;
    end
  end

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    an_d      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        sel_digit = count_q[4*k +: 4];
        sel_blank = blank[k];
        an_d[k]   = 1'b1;
      end
    end
    seg_raw = sel_blank ? 8'h00 : {1'b0, seg_pat(sel_digit)};
    seg_d   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    if (ACTIVE_LOW != 0) an_d = ~an_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_RST;
      an_q  <= AN_RST;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule
`default_nettype wire
